// File: rtl/idex_hazard_latch_if.sv
// ID/EX bundle: decode-stage inputs, EX-stage registered outputs,
// plus the load-use stall signalling back towards fetch/decode.
interface idex_hazard_latch_if;
  logic        en;
  logic        flush;
  logic [31:0] instr_ID;
  logic [31:0] pc4_ID;
  logic [31:0] rdat1_ID;
  logic [31:0] rdat2_ID;
  logic        RegWr_ID;
  logic        memWr_ID;
  logic        memtoReg_ID;
  logic [31:0] instr_EX;
  logic [31:0] pc4_EX;
  logic [31:0] rdat1_EX;
  logic [31:0] rdat2_EX;
  logic        RegWr_EX;
  logic        memWr_EX;
  logic        memtoReg_EX;
  logic        bubble_EX;
  logic        stall_ID;
  logic [31:0] stall_count;

  modport master (
    output en, flush,
    output instr_ID, pc4_ID, rdat1_ID, rdat2_ID,
    output RegWr_ID, memWr_ID, memtoReg_ID,
    input  instr_EX, pc4_EX, rdat1_EX, rdat2_EX,
    input  RegWr_EX, memWr_EX, memtoReg_EX,
    input  bubble_EX, stall_ID, stall_count
  );

  modport slave (
    input  en, flush,
    input  instr_ID, pc4_ID, rdat1_ID, rdat2_ID,
    input  RegWr_ID, memWr_ID, memtoReg_ID,
    output instr_EX, pc4_EX, rdat1_EX, rdat2_EX,
    output RegWr_EX, memWr_EX, memtoReg_EX,
    output bubble_EX, stall_ID, stall_count
  );
endinterface

// File: rtl/idex_hazard_latch.sv
// ID/EX pipeline latch with load-use hazard detection, bubble
// insertion on stall/flush and a saturating stall-cycle counter.
module idex_hazard_latch (
  input logic                 CLK,
  input logic                 RST,
  idex_hazard_latch_if.slave  bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic        regwr;
    logic        memwr;
    logic        memtoreg;
    logic        bubble;
  } id_ex_t;

  id_ex_t      ex_q, ex_d;
  logic [31:0] stall_count_q, stall_count_d;

  logic [5:0] op_id;
  logic [4:0] rs_id, rt_id, rt_ex;
  logic       uses_rt, hazard, stall;

  always_comb begin
    op_id   = bus.instr_ID[31:26];
    rs_id   = bus.instr_ID[25:21];
    rt_id   = bus.instr_ID[20:16];
    rt_ex   = ex_q.instr[20:16];
    uses_rt = (op_id == OP_RTYPE) | (op_id == OP_SW) |
              (op_id == OP_BEQ)   | (op_id == OP_BNE);
    hazard  = ex_q.memtoreg & ex_q.regwr & (rt_ex != 5'd0) &
              ((rs_id == rt_ex) | (uses_rt & (rt_id == rt_ex)));
    // a redirect squashes the consumer, so no stall is needed
    stall   = hazard & ~bus.flush;
  end

  always_comb begin
    ex_d          = ex_q;
    stall_count_d = stall_count_q;
    if (bus.en) begin
      if (bus.flush | stall) begin
        ex_d        = '0;
        ex_d.bubble = 1'b1;
      end else begin
        ex_d.instr    = bus.instr_ID;
        ex_d.pc4      = bus.pc4_ID;
        ex_d.rdat1    = bus.rdat1_ID;
        ex_d.rdat2    = bus.rdat2_ID;
        ex_d.regwr    = bus.RegWr_ID;
        ex_d.memwr    = bus.memWr_ID;
        ex_d.memtoreg = bus.memtoReg_ID;
        ex_d.bubble   = 1'b0;
      end
      if (stall && (stall_count_q != 32'hFFFF_FFFF))
        stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_q          <= '0;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.instr_EX    = ex_q.instr;
  assign bus.pc4_EX      = ex_q.pc4;
  assign bus.rdat1_EX    = ex_q.rdat1;
  assign bus.rdat2_EX    = ex_q.rdat2;
  assign bus.RegWr_EX    = ex_q.regwr;
  assign bus.memWr_EX    = ex_q.memwr;
  assign bus.memtoReg_EX = ex_q.memtoreg;
  assign bus.bubble_EX   = ex_q.bubble;
  assign bus.stall_ID    = stall;
  assign bus.stall_count = stall_count_q;

endmodule
